// File: rtl/ppi_bus_master_if.sv
// Host request/response handshake plus the PPI control strobes of ppi_bus_master.
//
// Handshake: a request transfers on a rising Clk edge where ReqValid=1 and
// ReqReady=1. ReqWr/ReqAddr/ReqData need to be valid only on that edge. The
// master never takes a request while ReqReady=0. Every accepted request ends in
// exactly one single-cycle Done pulse. Err and RspData are qualified by Done.
//
// Signals:
//   ReqValid/ReqReady    request handshake
//   ReqWr/ReqAddr/ReqData request payload (1 = write, PPI address, data)
//   Done/Err/RspData     completion pulse, reject flag, read data
//   nCs/nRe/nWr/A        PPI chip select, strobes and address
// PortD stays a plain inout on the module so the tristate net is visible at the top.
interface ppi_bus_master_if;
    logic       ReqValid;
    logic       ReqReady;
    logic       ReqWr;
    logic [1:0] ReqAddr;
    logic [7:0] ReqData;
    logic       Done;
    logic       Err;
    logic [7:0] RspData;
    logic       nCs;
    logic       nRe;
    logic       nWr;
    logic [1:0] A;

    // Bus-master (DUT) side.
    modport master (
        input  ReqValid, ReqWr, ReqAddr, ReqData,
        output ReqReady, Done, Err, RspData, nCs, nRe, nWr, A
    );

    // Host side that issues requests.
    modport slave (
        output ReqValid, ReqWr, ReqAddr, ReqData,
        input  ReqReady, Done, Err, RspData, nCs, nRe, nWr, A
    );
endinterface

// File: rtl/ppi_bus_master.sv
// Host-side sequencer for an 8255A PPI. It turns one accepted request into a
// timed bus cycle. The cycle has a setup phase with nCs, A and write data
// valid, then a strobe phase with nWr or nRe low, then a hold phase. Read data
// is captured from PortD. Completion is reported with a one-cycle Done pulse.
// A read of the control register (ReqWr=0, ReqAddr=11) is illegal on the 8255.
// It is rejected with Err=1 and RspData=FF, and it causes no bus activity.
//
// Ports:
//   Clk        system clock, rising edge
//   nReset     asynchronous active-low reset
//   bus        request/response handshake and PPI strobes (master modport)
//   PortD      PPI data bus. It is driven only during write cycles and is high-Z otherwise.
//   dbg_state  current FSM state (IDLE=0, SETUP=1, STROBE=2, HOLD=3, REJECT=4)
//   dbg_oe     registered PortD output enable
//
// Parameters (each legal 1..15): SETUP_CYC, STROBE_CYC, HOLD_CYC clocks per phase.
module ppi_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic                   Clk,
    input  logic                   nReset,
    ppi_bus_master_if.master       bus,
    inout  wire  [7:0]             PortD,
    output logic [2:0]             dbg_state,
    output logic                   dbg_oe
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        REJECT = 3'd4
    } state_t;

    // The counter is loaded with N-1, so a phase of N clocks ends on the edge where it reads 0.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       wr_q;
    logic [7:0] wdata_q;
    logic       oe;

    // The output enable is a register. Only the buffer itself is combinational.
    assign PortD     = oe ? wdata_q : 8'hzz;
    assign dbg_state = state;
    assign dbg_oe    = oe;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            wr_q         <= 1'b0;
            wdata_q      <= 8'h00;
            oe           <= 1'b0;
            bus.ReqReady <= 1'b1;
            bus.Done     <= 1'b0;
            bus.Err      <= 1'b0;
            bus.RspData  <= 8'h00;
            bus.nCs      <= 1'b1;
            bus.nRe      <= 1'b1;
            bus.nWr      <= 1'b1;
            bus.A        <= 2'b00;
        end else begin
            // Done and Err are pulses. Each completing state re-asserts them for one edge.
            bus.Done <= 1'b0;
            bus.Err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ReqValid && bus.ReqReady) begin
                        wr_q         <= bus.ReqWr;
                        wdata_q      <= bus.ReqData;
                        bus.ReqReady <= 1'b0;
                        if (!bus.ReqWr && (bus.ReqAddr == 2'b11)) begin
                            state <= REJECT;
                        end else begin
                            state   <= SETUP;
                            bus.nCs <= 1'b0;
                            bus.A   <= bus.ReqAddr;
                            oe      <= bus.ReqWr;
                            cnt     <= SETUP_LD;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        state <= STROBE;
                        cnt   <= STROBE_LD;
                        if (wr_q) begin
                            bus.nWr <= 1'b0;
                        end else begin
                            bus.nRe <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        state   <= HOLD;
                        cnt     <= HOLD_LD;
                        bus.nWr <= 1'b1;
                        bus.nRe <= 1'b1;
                        // This is the last edge that sees nRe low, so the PPI data is still valid here.
                        if (!wr_q) begin
                            bus.RspData <= PortD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        state        <= IDLE;
                        bus.nCs      <= 1'b1;
                        oe           <= 1'b0;
                        bus.Done     <= 1'b1;
                        bus.ReqReady <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                REJECT: begin
                    state        <= IDLE;
                    bus.Done     <= 1'b1;
                    bus.Err      <= 1'b1;
                    bus.RspData  <= 8'hFF;
                    bus.ReqReady <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Self-checking bench for ppi_bus_master. The main instance uses the default
// timing (1/2/1). A second instance uses 2/3/2 to check the stretched Done latency.
module tb_ppi_bus_master;

    localparam int S   = 1;
    localparam int T   = 2;
    localparam int H   = 1;
    localparam int LAT = S + T + H;

    typedef struct {
        logic       wr;
        logic [1:0] addr;
        logic [7:0] data;
        logic [7:0] ext;
        logic       keep;
        logic       err;
        logic       chk;
        logic [7:0] rsp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic nReset = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    ppi_bus_master_if bus1 ();
    ppi_bus_master_if bus2 ();
    wire  [7:0] PortD;
    wire  [7:0] PortD2;
    logic [2:0] dbg_state, dbg_state2;
    logic       dbg_oe, dbg_oe2;

    // External PPI stand-in that drives the data bus during reads.
    logic       tb_oe = 1'b0;
    logic [7:0] tb_d  = 8'h00;
    assign PortD = tb_oe ? tb_d : 8'hzz;

    ppi_bus_master dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .bus       (bus1),
        .PortD     (PortD),
        .dbg_state (dbg_state),
        .dbg_oe    (dbg_oe)
    );

    ppi_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut2 (
        .Clk       (Clk),
        .nReset    (nReset),
        .bus       (bus2),
        .PortD     (PortD2),
        .dbg_state (dbg_state2),
        .dbg_oe    (dbg_oe2)
    );

    // ---------------- trace + scoreboard ----------------
    logic [3:0] tr_s [0:4095];  // {nCs, nWr, nRe, oe}
    logic [1:0] tr_a [0:4095];
    logic [7:0] tr_d [0:4095];

    // Each entry is {err, check_rsp, rsp, done_cycle}.
    logic [25:0] exp_q[$];

    always @(negedge Clk) begin
        logic [25:0] e;
        tr_s[cyc % 4096] = {bus1.nCs, bus1.nWr, bus1.nRe, dbg_oe};
        tr_a[cyc % 4096] = bus1.A;
        tr_d[cyc % 4096] = PortD;
        if (nReset) begin
            total++;
            if ((!bus1.nRe && !bus1.nWr) || (dbg_oe && !bus1.nRe) || (bus1.Err && !bus1.Done)) begin
                bad++;
                $display("FAIL invariant cyc=%0d nRe=%b nWr=%b oe=%b Err=%b Done=%b required no overlap/contention/stray Err",
                         cyc, bus1.nRe, bus1.nWr, dbg_oe, bus1.Err, bus1.Done);
            end
            if (bus1.Done) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected cyc=%0d got Done=1 required no Done", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus1.Err !== e[25] || (e[24] && bus1.RspData !== e[23:16]) || cyc[15:0] !== e[15:0]) begin
                        bad++;
                        $display("FAIL done_check got err=%b rsp=%h cyc=%0d required err=%b rsp=%h cyc=%0d",
                                 bus1.Err, bus1.RspData, cyc, e[25], e[23:16], e[15:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // The caller is at a negedge. The request transfers on the next edge that sees ReqReady=1.
    task automatic send(input vec_t v, output int e0);
        int n;
        int lat;
        bus1.ReqWr    = v.wr;
        bus1.ReqAddr  = v.addr;
        bus1.ReqData  = v.data;
        bus1.ReqValid = 1'b1;
        tb_d          = v.ext;
        tb_oe         = !v.wr;
        lat           = v.err ? 1 : LAT;
        n = 0;
        while (bus1.ReqReady !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got ReqReady=%b required 1 within 100 cycles", bus1.ReqReady);
            bus1.ReqValid = 1'b0;
            e0 = 0;
            return;
        end
        @(negedge Clk);
        e0 = cyc;
        exp_q.push_back({v.err, v.chk, v.rsp, 16'(e0 + lat)});
        if (!v.keep) begin
            bus1.ReqValid = 1'b0;
            // The master must ignore this garbage while it is busy.
            bus1.ReqData  = ~v.data;
            bus1.ReqAddr  = ~v.addr;
            bus1.ReqWr    = ~v.wr;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge Clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL done_timeout got %0d outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        tb_oe = 1'b0;
    endtask

    // Independent waveform model for the default timing.
    task automatic check_trace(input vec_t v, input int e0);
        int lat;
        lat = v.err ? 1 : LAT;
        for (int k = 0; k <= lat; k++) begin
            int c;
            logic strobe;
            logic [3:0] es;
            c = (e0 + k) % 4096;
            strobe = !v.err && k >= S && k < S + T;
            es = {(v.err || k == lat), !(strobe && v.wr), !(strobe && !v.wr), (!v.err && v.wr && k < lat)};
            total++;
            if (tr_s[c] !== es) begin
                bad++;
                $display("FAIL trace_strobes e0=%0d k=%0d got {nCs,nWr,nRe,oe}=%b required %b", e0, k, tr_s[c], es);
            end
            if (!v.err) begin
                total++;
                if (tr_a[c] !== v.addr) begin
                    bad++;
                    $display("FAIL trace_addr e0=%0d k=%0d got A=%b required %b", e0, k, tr_a[c], v.addr);
                end
            end
            if (es[0]) begin
                total++;
                if (tr_d[c] !== v.data) begin
                    bad++;
                    $display("FAIL trace_wdata e0=%0d k=%0d got PortD=%h required %h", e0, k, tr_d[c], v.data);
                end
            end
        end
    endtask

    task automatic check_reset(input string name);
        logic [15:0] got;
        got = {bus1.nCs, bus1.nRe, bus1.nWr, dbg_oe, bus1.ReqReady, bus1.Done, bus1.Err, 1'b0, bus1.RspData};
        total++;
        if (got !== 16'b1110_1000_0000_0000 || dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL %s got {nCs,nRe,nWr,oe,Rdy,Done,Err,0,Rsp}=%b state=%0d required 1110100000000000 state=0",
                     name, got, dbg_state);
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs [0:8];
    int   e0s  [0:8];

    initial begin
        int first;
        int e0;
        int n;
        int ncs_low;
        int nwr_low;
        vec_t rv;

        vecs[0] = '{wr:1, addr:2'b11, data:8'h80, ext:8'h00, keep:0, err:0, chk:0, rsp:8'h00};
        vecs[1] = '{wr:1, addr:2'b00, data:8'hA1, ext:8'h00, keep:0, err:0, chk:0, rsp:8'h00};
        vecs[2] = '{wr:1, addr:2'b11, data:8'h9B, ext:8'h00, keep:0, err:0, chk:0, rsp:8'h00};
        vecs[3] = '{wr:0, addr:2'b01, data:8'h00, ext:8'h32, keep:0, err:0, chk:1, rsp:8'h32};
        vecs[4] = '{wr:0, addr:2'b00, data:8'h00, ext:8'h5C, keep:0, err:0, chk:1, rsp:8'h5C};
        vecs[5] = '{wr:0, addr:2'b11, data:8'h00, ext:8'h00, keep:0, err:1, chk:1, rsp:8'hFF};
        vecs[6] = '{wr:0, addr:2'b10, data:8'h00, ext:8'hC3, keep:0, err:0, chk:1, rsp:8'hC3};
        vecs[7] = '{wr:1, addr:2'b11, data:8'h0F, ext:8'h00, keep:1, err:0, chk:0, rsp:8'h00};
        vecs[8] = '{wr:1, addr:2'b11, data:8'h0E, ext:8'h00, keep:0, err:0, chk:0, rsp:8'h00};

        bus1.ReqValid = 1'b0; bus1.ReqWr = 1'b0; bus1.ReqAddr = 2'b00; bus1.ReqData = 8'h00;
        bus2.ReqValid = 1'b0; bus2.ReqWr = 1'b0; bus2.ReqAddr = 2'b00; bus2.ReqData = 8'h00;

        repeat (3) @(negedge Clk);
        check_reset("reset_held");
        nReset = 1'b1;
        @(negedge Clk);
        check_reset("reset_released");

        // Table-driven transactions. The keep entries chain back-to-back with ReqValid held high.
        first = 0;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i], e0s[i]);
            if (!vecs[i].keep) begin
                wait_idle();
                for (int j = first; j <= i; j++) check_trace(vecs[j], e0s[j]);
                first = i + 1;
            end
        end
        total++;
        if (e0s[8] - e0s[7] != LAT + 1) begin
            bad++;
            $display("FAIL back_to_back got spacing=%0d required %0d", e0s[8] - e0s[7], LAT + 1);
        end

        // Abort a write during its strobe phase.
        @(negedge Clk);
        bus1.ReqWr = 1'b1; bus1.ReqAddr = 2'b01; bus1.ReqData = 8'h5A; bus1.ReqValid = 1'b1;
        @(negedge Clk);  // the edge after this negedge accepts the request
        bus1.ReqValid = 1'b0;
        repeat (S) @(negedge Clk);
        total++;
        if (bus1.nWr !== 1'b0) begin
            bad++;
            $display("FAIL abort_pre got nWr=%b required 0", bus1.nWr);
        end
        #2 nReset = 1'b0;
        #1;
        total++;
        if ({bus1.nWr, bus1.nCs, dbg_oe, bus1.Done, bus1.ReqReady} !== 5'b11001) begin
            bad++;
            $display("FAIL abort_now got {nWr,nCs,oe,Done,Rdy}=%b required 11001",
                     {bus1.nWr, bus1.nCs, dbg_oe, bus1.Done, bus1.ReqReady});
        end
        repeat (2) @(negedge Clk);
        nReset = 1'b1;
        repeat (3) @(negedge Clk);
        check_reset("abort_recovered");
        rv = '{wr:0, addr:2'b00, data:8'h00, ext:8'h77, keep:0, err:0, chk:1, rsp:8'h77};
        send(rv, e0);
        wait_idle();
        check_trace(rv, e0);

        // Stretched timing on the second instance: 2/3/2 gives Done at E0+7.
        @(negedge Clk);
        bus2.ReqWr = 1'b1; bus2.ReqAddr = 2'b10; bus2.ReqData = 8'h3C; bus2.ReqValid = 1'b1;
        @(negedge Clk);
        e0 = cyc;
        bus2.ReqValid = 1'b0;
        n = 0; ncs_low = 0; nwr_low = 0;
        while (bus2.Done !== 1'b1 && n < 50) begin
            if (!bus2.nCs) ncs_low++;
            if (!bus2.nWr) nwr_low++;
            if (!bus2.nCs) begin
                total++;
                if (PortD2 !== 8'h3C) begin
                    bad++;
                    $display("FAIL p2_wdata got PortD=%h required 3c", PortD2);
                end
            end
            @(negedge Clk);
            n++;
        end
        total++;
        if (cyc - e0 != 7 || ncs_low != 7 || nwr_low != 3 || bus2.Err !== 1'b0) begin
            bad++;
            $display("FAIL p2_timing got done=E0+%0d ncs_low=%0d nwr_low=%0d err=%b required E0+7 7 3 0",
                     cyc - e0, ncs_low, nwr_low, bus2.Err);
        end

        repeat (3) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ppi_bus_master.md
Name: ppi_bus_master

Overview:
- Synchronous host-side bus sequencer that sits directly upstream of the 8255A PPI model.
- Converts a single-beat request/ready handshake into correctly timed nCs/A/nWr/nRe/PortD cycles: setup, strobe and hold phases, each counted in clocks.
- Captures read data from the shared PortD bus and returns it with a one-cycle Done pulse.
- Used to program control words, BSR commands and port data, and to read port data.

Parameters:
- SETUP_CYC, 1: clocks nCs/A (and write data) are valid before the strobe falls; legal range 1..15.
- STROBE_CYC, 2: clocks nWr/nRe is held low; legal range 1..15.
- HOLD_CYC, 1: clocks nCs/A (and write data) stay valid after the strobe rises; legal range 1..15.

Ports:
- Clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- ReqValid  input  1  host request present.
- ReqReady  output  1  block can accept a request (registered).
- ReqWr  input  1  1 = write cycle, 0 = read cycle.
- ReqAddr  input  2  PPI address: 00 = A, 01 = B, 10 = C, 11 = control.
- ReqData  input  8  write data or control word.
- Done  output  1  one-cycle completion pulse.
- Err  output  1  valid with Done; 1 = rejected request.
- RspData  output  8  read data; valid when Done=1 for reads, held until the next read.
- nCs  output  1  PPI chip select, active low.
- nRe  output  1  PPI read strobe, active low.
- nWr  output  1  PPI write strobe, active low.
- A  output  2  PPI address.
- PortD  inout  8  PPI data bus; driven only during write cycles, otherwise high-Z.

Behaviour:
- Reset (async, nReset=0), applied immediately:
  - nCs=1, nRe=1, nWr=1, A=00, PortD=Z.
  - ReqReady=1, Done=0, Err=0, RspData=8'h00.
  - State=IDLE; phase counter=0.
- A reset asserted mid-cycle aborts the transaction immediately: no Done, no data capture, strobe released in the same instant.
- All outputs are registered. The PortD output enable is a register; the tristate buffer is the only combinational element.
- States: IDLE, SETUP, STROBE, HOLD, REJECT. A 4-bit down-counter times each phase.
- IDLE:
  - ReqReady=1.
  - On an edge with ReqValid=1 and ReqReady=1, latch ReqWr/ReqAddr/ReqData and drop ReqReady.
  - If ReqWr=0 and ReqAddr=11 (control-register read, illegal on the 8255), go to REJECT.
  - Otherwise go to SETUP: nCs=0, A=latched address, PortD driven with latched data if write; counter=SETUP_CYC-1.
- SETUP: strobes high. When the counter hits 0, go to STROBE: nWr=0 (write) or nRe=0 (read); counter=STROBE_CYC-1.
- STROBE:
  - When the counter hits 0, go to HOLD and raise the strobe; counter=HOLD_CYC-1.
  - For reads, RspData captures PortD on this same edge, i.e. the last edge with nRe low.
- HOLD: nCs, A and write data stay stable. When the counter hits 0, go to IDLE: nCs=1, A held at its last value, PortD=Z, Done=1, Err=0, ReqReady=1.
- REJECT: no bus activity. Next edge: Done=1, Err=1, RspData=8'hFF, ReqReady=1, return to IDLE.
- Timing (E0 = accept edge):
  - Strobe falls at E0+SETUP_CYC.
  - Strobe rises at E0+SETUP_CYC+STROBE_CYC.
  - Done and nCs rise at E0+SETUP_CYC+STROBE_CYC+HOLD_CYC.
  - Defaults: 4-clock cycle; Done at E0+4.
- Back-to-back: a new request may be accepted on the edge ending the Done cycle, giving one transaction per (SETUP+STROBE+HOLD+1) clocks.
- Request inputs are ignored while ReqReady=0.
- Done and Err are low in every cycle except the completion cycle.
- nRe and nWr are never low simultaneously.
- PortD is never driven while nRe=0.
- Write data is stable from the nCs fall to the nCs rise.

Test Plan:
- Reset: hold nReset=0, then release → nCs=nRe=nWr=1, PortD=Z, ReqReady=1, Done=0, RspData=00.
- Control write: ReqWr=1, ReqAddr=11, ReqData=8'h80, defaults.
  - Required: nCs low from E0 to E0+4; nWr low exactly E0+1..E0+3; PortD=80 while nCs=0; Done=1, Err=0 one cycle at E0+4.
  - Follow with a Port A write of 8'hA1: PPI PortA=A1.
- Read after mode 8'h9B (all ports input), external PortB=8'h32, ReqAddr=01 read.
  - Required: nRe low two clocks, PortD never driven by the master, RspData=32 with Done.
- Illegal read: ReqWr=0, ReqAddr=11 → no nCs activity; Done=1, Err=1, RspData=FF at E0+1.
- Back-to-back BSR writes 8'h0F then 8'h0E, ReqValid held high → second accept on the edge ending the first Done; two distinct nWr pulses with nCs=1 for one clock between them; PPI PC7 set then cleared.
- Abort and parameters:
  - nReset=0 during STROBE of a write → nWr and nCs return to 1 immediately, PortD=Z, no Done; after release a read still works.
  - With SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2: Done at E0+7.
